// File: rtl/token_pkg.sv
// Shared definitions for the serial token multiplier: cause-bit indices,
// default run limit and pending-counter sizing.
package token_pkg;

  localparam int OVF_RUN     = 0;
  localparam int OVF_CAP     = 1;
  localparam int DEF_MAX_RUN = 200;

  // Wide enough to hold the tokens owed by a full-length run at the largest factor
  function automatic int calc_pend_w(input int max_run, input int max_mult);
    return $clog2(max_run * (max_mult - 1) + 1);
  endfunction

endpackage

// File: rtl/token_run_monitor.sv
// Consecutive-token run counter plus the sticky overflow-cause register.
module token_run_monitor
  import token_pkg::*;
#(
  parameter int MAX_RUN = DEF_MAX_RUN
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       cap_evt,
  input  logic       clr_ovf,
  output logic [1:0] ovf_cause
);

  localparam int             RW      = $clog2(MAX_RUN + 1);
  localparam logic [RW-1:0]  RUN_MAX = RW'(MAX_RUN);

  logic [RW-1:0] run_len;
  logic [1:0]    evt;

  always_comb begin
    evt          = '0;
    evt[OVF_RUN] = a && (run_len == RUN_MAX);
    evt[OVF_CAP] = cap_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  run_len <= '0;
    else if (!a)                 run_len <= '0;
    else if (run_len != RUN_MAX) run_len <= run_len + 1'b1;
  end

  // A clear coinciding with a fresh event keeps only the fresh cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_cause <= '0;
    else if (clr_ovf) ovf_cause <= evt;
    else              ovf_cause <= ovf_cause | evt;
  end

endmodule

// File: rtl/token_multiplier.sv
// Serial token multiplier: each input '1' is emitted m_eff times on b, the
// first copy combinationally and the rest serialised via a pending counter.
module token_multiplier
  import token_pkg::*;
#(
  parameter  int MAX_MULT = 4,
  parameter  int MAX_RUN  = DEF_MAX_RUN,
  localparam int MW       = $clog2(MAX_MULT + 1),
  localparam int PEND_W   = calc_pend_w(MAX_RUN, MAX_MULT)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic [MW-1:0]     mult,
  input  logic              clr_ovf,
  output logic              b,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic [1:0]        ovf_cause
);

  localparam int                SW       = PEND_W + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [MW-1:0]     MULT_MAX = MW'(MAX_MULT);

  logic [MW-1:0]     m_eff;
  logic [PEND_W:0]   pend_sum;
  logic              cap_evt;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;

  always_comb begin
    m_eff = mult;
    if (mult == '0)          m_eff = MW'(1);
    else if (mult > MULT_MAX) m_eff = MULT_MAX;
  end

  // PEND_MAX is all ones, so the carry bit alone flags a capacity overflow
  assign pend_sum = {1'b0, pend_q} + SW'(m_eff - 1'b1);
  assign cap_evt  = a && pend_sum[PEND_W];

  always_comb begin
    pend_d = pend_q;
    if (a)                 pend_d = cap_evt ? PEND_MAX : pend_sum[PEND_W-1:0];
    else if (pend_q != '0) pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending  = pend_q;
  assign busy     = |pend_q;
  assign b        = rst_n && (a || busy);
  assign overflow = |ovf_cause;

  token_run_monitor #(
    .MAX_RUN (MAX_RUN)
  ) u_run_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .cap_evt   (cap_evt),
    .clr_ovf   (clr_ovf),
    .ovf_cause (ovf_cause)
  );

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier with a cycle-level reference model.
module tb_token_multiplier;

  localparam int MAX_MULT = 4;
  localparam int MAX_RUN  = 200;
  localparam int MW       = $clog2(MAX_MULT + 1);
  localparam int PEND_W   = $clog2(MAX_RUN * (MAX_MULT - 1) + 1);
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [MW-1:0]     mult = '0;
  logic              b, busy, overflow;
  logic [PEND_W-1:0] pending;
  logic [1:0]        ovf_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  token_multiplier #(.MAX_MULT(MAX_MULT), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .mult(mult), .clr_ovf(clr_ovf),
    .b(b), .busy(busy), .pending(pending), .overflow(overflow), .ovf_cause(ovf_cause)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owed-token count, run length and sticky causes
  int         m_pend = 0;
  int         m_run = 0;
  logic [1:0] m_cause = 2'b00;

  always @(posedge clk or negedge rst_n) begin : model
    int me, np, nr;
    logic [1:0] ev;
    if (!rst_n) begin
      m_pend  <= 0;
      m_run   <= 0;
      m_cause <= 2'b00;
    end else begin
      me = (mult == 0) ? 1 : ((int'(mult) > MAX_MULT) ? MAX_MULT : int'(mult));
      ev = 2'b00;
      np = m_pend;
      nr = m_run;
      if (a) begin
        if (m_pend + me - 1 > PEND_MAX) begin np = PEND_MAX; ev[1] = 1'b1; end
        else np = m_pend + me - 1;
        if (m_run == MAX_RUN) ev[0] = 1'b1;
        else nr = m_run + 1;
      end else begin
        if (m_pend > 0) np = m_pend - 1;
        nr = 0;
      end
      m_pend  <= np;
      m_run   <= nr;
      m_cause <= clr_ovf ? ev : (m_cause | ev);
    end
  end

  always @(negedge clk) begin
    chk("cmp_b", b, rst_n && (a || m_pend != 0));
    chk("cmp_pending", pending, m_pend);
    chk("cmp_busy", busy, m_pend != 0);
    chk("cmp_ovf_cause", ovf_cause, m_cause);
    chk("cmp_overflow", overflow, m_cause != 0);
  end

  // Drive one cycle: b sampled mid-cycle, pending sampled just after the edge
  task automatic step(input logic ai, input int mi, input logic ci,
                      output logic ob, output int op);
    a = ai; mult = mi[MW-1:0]; clr_ovf = ci;
    @(negedge clk);
    ob = b;
    @(posedge clk); #1;
    op = int'(pending);
  endtask

  logic [25:0] t1_a = 26'b10010011000110100001100100;
  logic [25:0] t1_b = 26'b11011011110111111001111110;
  int t2_a[12] = '{1,0,0,0,0, 1,1,0,0,0,0,0};
  int t2_b[12] = '{1,1,1,0,0, 1,1,1,1,1,1,0};
  int t2_p[12] = '{2,1,0,0,0, 2,4,3,2,1,0,0};
  int t3_a[12] = '{1,1,0,0,0,0, 1,0, 1,0,0,0};
  int t3_m[12] = '{4,1,1,1,1,1, 0,0, 7,1,1,1};
  int t3_b[12] = '{1,1,1,1,1,0, 1,0, 1,1,1,1};
  int t3_p[12] = '{3,3,2,1,0,0, 0,0, 3,2,1,0};

  initial begin : stim
    logic ob;
    int   op;
    a = 1'b1; mult = 3'd4;
    #12;
    chk("rst_b", b, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    a = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      step(t1_a[25-i], 2, 1'b0, ob, op);
      chk("t1_double_b", ob, t1_b[25-i]);
    end
    chk("t1_overflow", overflow, 0);

    for (int i = 0; i < 12; i++) begin
      step(t2_a[i][0], 3, 1'b0, ob, op);
      chk("t2_triple_b", ob, t2_b[i]);
      chk("t2_triple_pending", op, t2_p[i]);
    end

    for (int i = 0; i < 12; i++) begin
      step(t3_a[i][0], t3_m[i], 1'b0, ob, op);
      chk("t3_factor_b", ob, t3_b[i]);
      chk("t3_factor_pending", op, t3_p[i]);
    end

    for (int i = 0; i < 200; i++) step(1'b1, 1, 1'b0, ob, op);
    chk("t4_run200_overflow", overflow, 0);
    chk("t4_passthru_pending", op, 0);
    step(1'b1, 1, 1'b0, ob, op);
    chk("t4_run201_cause", ovf_cause, 2'b01);
    for (int i = 0; i < 50; i++) step(1'b0, 1, 1'b0, ob, op);
    chk("t4_sticky", overflow, 1);
    step(1'b0, 1, 1'b1, ob, op);
    chk("t4_clear", ovf_cause, 2'b00);

    for (int i = 0; i < 200; i++) step(1'b1, 4, 1'b0, ob, op);
    chk("t5_pend600", op, 600);
    step(1'b0, 4, 1'b0, ob, op);
    chk("t5_pend599", op, 599);
    for (int i = 0; i < 141; i++) step(1'b1, 4, 1'b0, ob, op);
    chk("t5_pend1022", op, 1022);
    chk("t5_no_ovf_yet", ovf_cause, 2'b00);
    step(1'b1, 4, 1'b1, ob, op);
    chk("t5_sat", op, 1023);
    chk("t5_set_beats_clr", ovf_cause, 2'b10);
    step(1'b1, 4, 1'b0, ob, op);
    chk("t5_hold_sat", op, 1023);
    chk("t5_b_runs", ob, 1);

    #3 rst_n = 1'b0;
    #1;
    chk("t6a_b", b, 0);
    chk("t6a_pending", pending, 0);
    chk("t6a_overflow", overflow, 0);
    a = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, ob, op);
    step(1'b0, 3, 1'b0, ob, op);
    chk("t6_pend5", op, 5);
    chk("t6_b_before", b, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_b", b, 0);
    chk("t6_pending", pending, 0);
    chk("t6_busy", busy, 0);
    chk("t6_overflow", overflow, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 3, 1'b0, ob, op);
    chk("t6_post_b", ob, 1);
    chk("t6_post_pending", op, 2);
    step(1'b0, 3, 1'b0, ob, op);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/token_multiplier.md
Name: token_multiplier

Overview:
Serial token multiplier, the parametrised successor of the doubling block. Each incoming '1' on `a` is emitted `mult` times on `b`. `mult` is a runtime per-token factor, up to MAX_MULT. Owed tokens are serialised into the following cycles. Overflow is sticky and reports its cause: an excessive consecutive run, or exhaustion of the pending counter. A software-style clear input is added. The block sits in the serial token-processing datapath between a bit-serial source and a bit-serial consumer.

Parameters:
MAX_MULT, 4, largest supported multiplication factor (>=2).
MAX_RUN, 200, longest run of consecutive input '1's accepted without run overflow (>=1).
MW (localparam), $clog2(MAX_MULT+1), width of `mult`.
PEND_W (localparam), $clog2(MAX_RUN*(MAX_MULT-1)+1), width of the pending counter; PEND_MAX = 2**PEND_W-1.

Ports:
clk  input  1  single clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
a  input  1  serial input token stream.
mult  input  MW  multiplication factor, sampled in every cycle where a=1; value 0 is treated as 1.
clr_ovf  input  1  synchronous clear of overflow and ovf_cause.
b  output  1  serial output token stream.
busy  output  1  pending != 0.
pending  output  PEND_W  count of owed tokens not yet emitted.
overflow  output  1  sticky error flag, equals |ovf_cause.
ovf_cause  output  2  sticky cause bits: [0] run overflow, [1] capacity overflow.

Behaviour:
- Reset: rst_n low clears pending, run_len, overflow and ovf_cause immediately, without waiting for clk.
  - b is forced to 0 while rst_n is low.
  - busy, pending, overflow and ovf_cause all read 0 during reset.
- b is combinational: b = rst_n && (a || pending != 0). Zero latency for the first copy of each token.
- Effective factor: m_eff = (mult==0) ? 1 : min(mult, MAX_MULT).
- Pending update per clk edge:
  - a=1: pending += m_eff-1.
  - a=0 and pending!=0: pending -= 1.
  - otherwise pending holds.
- A token is never emitted twice in one cycle. When a=1 and pending>0, the owed tokens wait.
- Factor is per token: changing `mult` mid-stream affects only tokens arriving at or after the change.
- Capacity: if pending + m_eff - 1 > PEND_MAX, pending saturates at PEND_MAX and ovf_cause[1] sets on the same edge. Excess tokens are dropped.
- Run tracking: run_len counts consecutive cycles with a=1, saturating at MAX_RUN, and clears to 0 on a=0.
  - ovf_cause[0] sets on an edge where a=1 and run_len==MAX_RUN, i.e. on the (MAX_RUN+1)-th consecutive token.
- Sticky flags: set on the edge after the offending token; visible one cycle later.
  - They remain set until rst_n is low, or until clr_ovf=1 at an edge.
  - clr_ovf and a new overflow event on the same edge: the set wins, and only the new cause bit remains.
- The datapath keeps running after overflow. Overflow never blocks `a` or `b`.
- mult=1 everywhere gives pass-through (b==a) with pending held at 0.
- mult=2 reproduces the legacy doubling behaviour exactly.

Decomposition:
- Shared package token_pkg holds:
  - OVF_RUN=0 and OVF_CAP=1 cause-bit indices.
  - A localparam function computing PEND_W from MAX_RUN and MAX_MULT.
  - The default MAX_RUN=200.
- Sub-module token_run_monitor, parameter MAX_RUN:
  - Inputs: clk, rst_n, a, cap_evt, clr_ovf.
  - Contains the run counter and the sticky ovf_cause register.
- The top level holds factor decode, the pending counter and the b logic.

Test Plan:
- mult=2; a=10010011000110100001100100 -> b=11011011110111111001111110. overflow stays 0.
- mult=3; a=1,0,0,0,0 -> b=1,1,1,0,0 and pending=2,1,0,0. Then a=1,1,0,0,0,0,0 -> b=1,1,1,1,1,1,0.
- Per-token factor: a=1 with mult=4, then a=1 with mult=1, then a=0 x4 -> b=1,1,1,1,1,0 and pending peaks at 3. Also mult=0 with a=1 -> b=1 and pending=0.
- Run overflow, mult=1: 200 consecutive '1's give overflow=0. The 201st '1' -> overflow=1 and ovf_cause=01 the next cycle. Remains 1 through 50 cycles of a=0. clr_ovf pulse -> 0.
- Capacity overflow (MAX_MULT=4, MAX_RUN=200, PEND_MAX=1023), mult=4 throughout:
  - Stimulus: 200 x '1', then one '0', then '1's.
  - Expected: pending=600, then 599. The 142nd token of the second run sets ovf_cause[1] and saturates pending at 1023.
  - The simultaneous-edge check: clr_ovf asserted on that same edge still leaves ovf_cause=10.
- Async reset mid-stream (mult=3, pending=5): drop rst_n between clock edges -> b, pending, busy and overflow go to 0 immediately.
  - Release, then a=1 -> b=1 and pending=2 on the next edge.
